lcd_cmd_seq: RTL

Command sequencer in front of the LCD image controller. Buffers host commands in a small FIFO and issues them one at a time on the controller's `cmd`/`cmd_valid` port, only when `busy` is low. It then tracks each command through the controller's busy pulse. After a WRITE (code 0) is issued, it stops accepting commands and waits for `done`, then reports `seq_done`.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_cmd_fifo.sv | 47 ++++
 rtl/lcd_cmd_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: command codes, the sequencer
// state encoding and a legality check on incoming codes.
package lcd_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_WRITE       = 4'd0,
        CMD_BRIGHT_UP   = 4'd1,
        CMD_BRIGHT_DN   = 4'd2,
        CMD_CONTRAST_UP = 4'd3,
        CMD_CONTRAST_DN = 4'd4,
        CMD_INVERT      = 4'd5,
        CMD_GRAY        = 4'd6,
        CMD_ROT_L       = 4'd7,
        CMD_ROT_R       = 4'd8,
        CMD_ZOOM_IN     = 4'd9,
        CMD_MIRROR_X    = 4'd10,
        CMD_MIRROR_Y    = 4'd11
    } lcd_cmd_t;

    localparam logic [CMD_W-1:0] CMD_LAST = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_EXEC,
        ST_FLUSH,
        ST_FIN
    } seq_state_t;

    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] code);
        return code <= CMD_LAST;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous circular-buffer FIFO; the extra pointer bit distinguishes
// full from empty when the index bits match.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = CMD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/lcd_cmd_seq.sv
// Command sequencer: queues host commands and issues them to the LCD
// controller one at a time, tracking each through the controller's busy pulse.
module lcd_cmd_seq
    import lcd_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CMD_W-1:0] host_cmd,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             busy,
    input  logic             done,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             seq_done,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [7:0]       issued_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] ACK_LAST = TW'(TIMEOUT - 1);

    seq_state_t       state;
    logic [TW-1:0]    ack_cnt;
    logic             wr_seen;
    logic             push_fire;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_head;

    assign host_ready = !fifo_full && !wr_seen && !seq_done;
    assign push_fire  = host_valid && host_ready;
    // Illegal codes complete the handshake but never reach the queue.
    assign fifo_push  = push_fire && cmd_is_legal(host_cmd);
    assign fifo_pop   = (state == ST_ISSUE);

    lcd_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (host_cmd),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_seen     <= 1'b0;
            err_illegal <= 1'b0;
        end else if (push_fire) begin
            if (!cmd_is_legal(host_cmd))
                err_illegal <= 1'b1;
            if (host_cmd == CMD_WRITE)
                wr_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            seq_done    <= 1'b0;
            err_timeout <= 1'b0;
            issued_cnt  <= '0;
            ack_cnt     <= '0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Outputs are loaded on entry so the strobe coincides with ISSUE.
                    if (!fifo_empty && !busy) begin
                        state     <= ST_ISSUE;
                        cmd       <= fifo_head;
                        cmd_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issued_cnt != 8'hFF)
                        issued_cnt <= issued_cnt + 8'd1;
                    ack_cnt <= '0;
                    state   <= (cmd == CMD_WRITE) ? ST_FLUSH : ST_ACK;
                end
                ST_ACK: begin
                    if (busy) begin
                        state <= ST_EXEC;
                    end else if (ack_cnt == ACK_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + TW'(1);
                    end
                end
                ST_EXEC: begin
                    if (!busy)
                        state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    if (done) begin
                        seq_done <= 1'b1;
                        state    <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_FIN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
